// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph codes, digit enables and arbiter state encoding
//               for the 4-digit 7-segment display blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [3:0] GLYPH_P     = 4'd10;
  localparam logic [3:0] GLYPH_UP    = 4'd11;
  localparam logic [3:0] GLYPH_DOWN  = 4'd12;
  localparam logic [3:0] GLYPH_DASH  = 4'd13;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  localparam logic [3:0] DIG0 = 4'b1110;
  localparam logic [3:0] DIG1 = 4'b1101;
  localparam logic [3:0] DIG2 = 4'b1011;
  localparam logic [3:0] DIG3 = 4'b0111;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    BASE = 1'b0,
    OVL  = 1'b1
  } arb_state_t;

  // One-cold digit enable for a scan index; never more than one zero bit.
  function automatic logic [3:0] dig_enable(input logic [1:0] idx);
    logic [3:0] en;
    case (idx)
      2'd0:    en = DIG0;
      2'd1:    en = DIG1;
      2'd2:    en = DIG2;
      default: en = DIG3;
    endcase
    return en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
// ============================================================================
// Module      : seg7_glyph_decode
// Description : 4-bit glyph code to active-low segments (bit6=g .. bit0=a).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:       seg = 7'b1000000;
      4'd1:       seg = 7'b1111001;
      4'd2:       seg = 7'b0100100;
      4'd3:       seg = 7'b0110000;
      4'd4:       seg = 7'b0011001;
      4'd5:       seg = 7'b0010010;
      4'd6:       seg = 7'b0000010;
      4'd7:       seg = 7'b1111000;
      4'd8:       seg = 7'b0000000;
      4'd9:       seg = 7'b0010000;
      GLYPH_P:    seg = 7'b0001100;
      // Direction markers: top bar for up, bottom bar for down.
      GLYPH_UP:   seg = 7'b1111110;
      GLYPH_DOWN: seg = 7'b1110111;
      GLYPH_DASH: seg = 7'b0111111;
      default:    seg = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module      : seg_display_arbiter
// Description : Scans a 4-digit 7-segment display, arbitrating between a live
//               base code and a timed overlay message, with blink gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 2500,
  parameter int BLINK_DIV = 50000000,
  parameter int OVL_HOLD  = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_code,
  input  logic [3:0]  blank_mask,
  input  logic        ovl_req,
  input  logic [15:0] ovl_code,
  input  logic        ovl_cancel,
  input  logic        blink_en,
  output logic        ovl_busy,
  output logic        ovl_ack,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  localparam int c_scan_w  = $clog2(SCAN_DIV);
  localparam int c_blink_w = $clog2(BLINK_DIV);
  localparam int c_hold_w  = $clog2(OVL_HOLD);

  localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
  localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(OVL_HOLD - 1);

  arb_state_t           r_state;
  logic [c_scan_w-1:0]  r_scan_cnt;
  logic [1:0]           r_idx;
  logic [c_hold_w-1:0]  r_hold_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_off;
  logic [15:0]          r_ovl_code;

  logic [3:0] w_base_nib;
  logic [3:0] w_ovl_nib;
  logic [3:0] w_glyph;
  logic [6:0] w_seg;
  logic       w_blank_now;

  assign w_base_nib = base_code[{r_idx, 2'b00} +: 4];
  assign w_ovl_nib  = r_ovl_code[{r_idx, 2'b00} +: 4];

  // Blank mask only ever hides base digits; overlay glyphs are shown as sent.
  always_comb begin
    w_glyph = w_base_nib;
    if (r_state == OVL) begin
      w_glyph = w_ovl_nib;
    end else if (blank_mask[r_idx]) begin
      w_glyph = GLYPH_BLANK;
    end
  end

  // Gating on blink_en lets segments return on the edge blink is dropped.
  assign w_blank_now = blink_en & r_blink_off;

  seg7_glyph_decode u_decode (
    .code (w_glyph),
    .seg  (w_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
      DIGIT       <= 4'b1111;
      DISPLAY     <= SEG_OFF;
    end else begin
      if (r_scan_cnt == c_scan_last) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
      end

      if (!blink_en) begin
        r_blink_cnt <= '0;
        r_blink_off <= 1'b0;
      end else if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
      end

      DIGIT   <= dig_enable(r_idx);
      DISPLAY <= w_blank_now ? SEG_OFF : w_seg;
    end
  end

  // A request always wins: it retriggers over cancel and over hold expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BASE;
      r_hold_cnt <= '0;
      r_ovl_code <= 16'hFFFF;
      ovl_busy   <= 1'b0;
      ovl_ack    <= 1'b0;
    end else begin
      ovl_ack <= ovl_req;
      if (ovl_req) begin
        r_ovl_code <= ovl_code;
        r_hold_cnt <= '0;
        r_state    <= OVL;
        ovl_busy   <= 1'b1;
      end else if (r_state == OVL) begin
        if (ovl_cancel || (r_hold_cnt == c_hold_last)) begin
          r_hold_cnt <= '0;
          r_state    <= BASE;
          ovl_busy   <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Owns the 4-digit 7-segment display and multiplexes it between two clients.
- The base client is the counter/stopwatch datapath, with a live 16-bit code.
- The overlay client sends short status messages such as "P---" or "UP" and has priority for a fixed hold time.
- The block also generates digit scan timing, blink gating and per-digit blanking, and drives DIGIT/DISPLAY directly at top level.

Parameters:
- SCAN_DIV, 2500, clk cycles each digit stays enabled (≥2).
- BLINK_DIV, 50000000, clk cycles per blink half-period (≥2).
- OVL_HOLD, 100000000, clk cycles an overlay stays displayed after its last request (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- base_code  in  16  base client glyph codes; nibble [3:0] is the rightmost digit, [15:12] the leftmost
- blank_mask  in  4  bit i=1 blanks digit i of the base code only
- ovl_req  in  1  one-cycle pulse: latch ovl_code and show it
- ovl_code  in  16  overlay glyph codes, same nibble order as base_code
- ovl_cancel  in  1  one-cycle pulse: drop the overlay immediately
- blink_en  in  1  level: blink the whole display
- ovl_busy  out  1  registered; 1 while state=OVL
- ovl_ack  out  1  one-cycle pulse, the cycle after an accepted ovl_req
- DIGIT  out  4  active-low digit enables
- DISPLAY  out  7  active-low segments; bit6=g … bit0=a

Behaviour:
- Reset (rst=0, async) values:
  - DIGIT=4'b1111, DISPLAY=7'b1111111, ovl_busy=0, ovl_ack=0.
  - state=BASE; scan_cnt, idx, hold_cnt, blink_cnt=0; blink phase=ON; latched overlay=16'hFFFF.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At scan_cnt==SCAN_DIV-1, idx advances 0→1→2→3→0.
  - Digit enables per idx: 0→1110, 1→1101, 2→1011, 3→0111.
- Output registration:
  - DIGIT and DISPLAY are registered together every cycle from the current idx and source, so latency is 1 cycle.
  - DIGIT never has more than one zero bit.
- Source select:
  - state=OVL selects the latched overlay nibble idx.
  - state=BASE selects base_code nibble idx, sampled live with no handshake; if blank_mask[idx]=1 the glyph is forced to 15 (blank).
- Glyph decode (combinational, before the output register):
  - 0-9 decimal digits; 10 "P"; 11 "UP"; 12 "DOWN"; 13 "-"; 14 and 15 blank (7'h7F).
- State machine with two states, BASE and OVL:
  - ovl_req in any state: latch ovl_code, hold_cnt<=0, state<=OVL, ovl_ack=1 next cycle.
  - In OVL, hold_cnt increments each cycle; at hold_cnt==OVL_HOLD-1 the state returns to BASE.
  - ovl_cancel in OVL returns to BASE next cycle; ovl_cancel in BASE is ignored.
- Simultaneous events:
  - ovl_req with ovl_cancel: req wins, giving a retrigger.
  - ovl_req on the expiry cycle: req wins and the hold restarts from 0.
  - Back-to-back ovl_req pulses: each is acked, and each restarts the hold.
- Blink:
  - With blink_en=1, blink_cnt counts 0..BLINK_DIV-1 and the phase toggles on wrap.
  - In the OFF phase, DISPLAY=7'h7F while DIGIT keeps scanning.
  - blink_en=0 immediately clears blink_cnt and sets phase=ON.
  - Blink applies to both sources.
- Reset mid-overlay: overlay discarded, state BASE, counters restart; no ack is issued.
- Counter widths are $clog2(param); all wrap compares use equality to param-1.

Decomposition:
- Shared package seg7_pkg contains:
  - glyph code constants: GLYPH_P=10, GLYPH_UP=11, GLYPH_DOWN=12, GLYPH_DASH=13, GLYPH_BLANK=15;
  - the digit-enable constants DIG0..DIG3 and SEG_OFF=7'h7F;
  - the state encoding BASE=0, OVL=1.
- One sub-module, seg7_glyph_decode: 4-bit code to 7-bit active-low segments, combinational, shared with other display blocks.
- Scan, blink and hold counters stay inline.

Test Plan (SCAN_DIV=4, BLINK_DIV=8, OVL_HOLD=10):
- Reset with base_code=16'h1234, mask=0 → DIGIT/DISPLAY=1111/7F during reset; after release DIGIT cycles 1110,1101,1011,0111, each for 4 cycles, with DISPLAY=4,3,2,1 glyphs (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001).
- blank_mask=4'b1100, base=16'h0042 → digits 3 and 2 show 7F; digits 1 and 0 show "4" and "2".
- ovl_req with ovl_code=16'hADDD → ovl_ack high exactly one cycle later; ovl_busy=1; display shows "P---" for 10 cycles, then returns to base; ovl_busy=0.
- ovl_req again at hold_cnt=7, then ovl_cancel 3 cycles later → hold restarts at the retrigger; BASE resumes 1 cycle after the cancel. A simultaneous req+cancel keeps OVL.
- blink_en=1 for 32 cycles → DISPLAY forced 7F for alternate 8-cycle windows while DIGIT keeps scanning; dropping blink_en mid-OFF restores segments next cycle.
- Assert rst during OVL, then release → ovl_busy=0, no ack, base shown, idx restarts at 0.
